// File: rtl/nvdla_afifo_wr_ctrl_if.sv
// Push/RAM/pointer bundle between a write-side producer and the async FIFO
// write controller. The controller connects through the slave modport.
interface nvdla_afifo_wr_ctrl_if #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned WIDTH      = 32
);
  localparam int unsigned AW = DEPTH_LOG2;

  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic [AW:0]      rd_ptr_gray_sync;
  logic             enable_w;
  logic             ram_we;
  logic [AW-1:0]    ram_wa;
  logic [WIDTH-1:0] ram_wd;
  logic [AW:0]      wr_ptr_gray;
  logic [AW:0]      wr_count;
  logic             wr_clk_en;
  logic             ovf_err;

  modport master (
    output wr_pvld, wr_pd, rd_ptr_gray_sync, enable_w,
    input  wr_prdy, ram_we, ram_wa, ram_wd, wr_ptr_gray, wr_count,
           wr_clk_en, ovf_err
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_ptr_gray_sync, enable_w,
    output wr_prdy, ram_we, ram_wa, ram_wd, wr_ptr_gray, wr_count,
           wr_clk_en, ovf_err
  );
endinterface

// File: rtl/nvdla_afifo_wr_ctrl.sv
// Write-domain controller for NVDLA async FIFOs: push handshake, RAM write
// port, binary/Gray write pointers, full detection against the synchronized
// read pointer, and the DFT-qualified write clock-gate enable.
module nvdla_afifo_wr_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  nvdla_afifo_wr_ctrl_if.slave bus
);
  localparam int unsigned AW = DEPTH_LOG2;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW:0]      wr_ptr_bin_q,  wr_ptr_bin_d;
  logic [AW:0]      wr_ptr_gray_q, wr_ptr_gray_d;
  logic             ram_we_q,      ram_we_d;
  logic [AW-1:0]    ram_wa_q,      ram_wa_d;
  logic [WIDTH-1:0] ram_wd_q,      ram_wd_d;
  logic             ovf_err_q,     ovf_err_d;

  logic [AW:0] rd_ptr_bin;
  logic [AW:0] wr_count;
  logic        wr_prdy;
  logic        acc;
  logic        gray_pend;

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of all
  // Gray bits at or above i.
  always_comb begin
    rd_ptr_bin = '0;
    for (int unsigned i = 0; i <= AW; i++) begin
      rd_ptr_bin[i] = ^(bus.rd_ptr_gray_sync >> i);
    end
  end

  // Occupancy, handshake and clock-gate enable from registered state.
  always_comb begin
    wr_count  = wr_ptr_bin_q - rd_ptr_bin;
    wr_prdy   = bus.enable_w & (wr_count < FULL_LVL);
    acc       = bus.wr_pvld & wr_prdy;
    gray_pend = (wr_ptr_gray_q != bin2gray(wr_ptr_bin_q));
  end

  // Next-state: pointer advance, RAM write stage capture, Gray publish of the
  // current (pre-advance) pointer so it trails the RAM write by a cycle.
  always_comb begin
    wr_ptr_bin_d  = wr_ptr_bin_q + {{AW{1'b0}}, acc};
    wr_ptr_gray_d = bin2gray(wr_ptr_bin_q);
    ram_we_d      = acc;
    ram_wa_d      = ram_wa_q;
    ram_wd_d      = ram_wd_q;
    if (acc) begin
      ram_wa_d = wr_ptr_bin_q[AW-1:0];
      ram_wd_d = bus.wr_pd;
    end
    ovf_err_d     = ovf_err_q | (wr_count > FULL_LVL);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      ram_we_q      <= 1'b0;
      ram_wa_q      <= '0;
      ram_wd_q      <= '0;
      ovf_err_q     <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      ram_we_q      <= ram_we_d;
      ram_wa_q      <= ram_wa_d;
      ram_wd_q      <= ram_wd_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  assign bus.wr_prdy     = wr_prdy;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wa      = ram_wa_q;
  assign bus.ram_wd      = ram_wd_q;
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.wr_count    = wr_count;
  assign bus.wr_clk_en   = bus.enable_w & (bus.wr_pvld | ram_we_q | gray_pend);
  assign bus.ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_nvdla_afifo_wr_ctrl.sv
// Self-checking bench for nvdla_afifo_wr_ctrl at DEPTH_LOG2=2, WIDTH=8:
// directed scenarios plus a randomized run against a count-based model.
module tb_nvdla_afifo_wr_ctrl;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  nvdla_afifo_wr_ctrl_if #(.DEPTH_LOG2(2), .WIDTH(8)) bus ();

  nvdla_afifo_wr_ctrl #(.DEPTH_LOG2(2), .WIDTH(8)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: total accepts since reset and expected registered outputs.
  int m_pushes;
  int m_we;
  int m_wa;
  int m_wd;
  int m_gray;
  int m_ovf;

  function automatic int gr(input int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  // Inverse Gray by search over the 8 pointer values.
  function automatic int rdbin(input int g);
    for (int b = 0; b < 8; b++) if (gr(b) == g) return b;
    return 0;
  endfunction

  function automatic int exp_count();
    return (m_pushes - rdbin(int'(bus.rd_ptr_gray_sync))) & 7;
  endfunction

  function automatic int exp_rdy();
    return (bus.enable_w && exp_count() < 4) ? 1 : 0;
  endfunction

  function automatic int exp_clk_en();
    return (bus.enable_w && (bus.wr_pvld || m_we != 0 || m_gray != gr(m_pushes & 7))) ? 1 : 0;
  endfunction

  // Advance one clock and update the model from the inputs applied this cycle.
  task automatic tick();
    int cnt;
    int acc;
    int pd;
    cnt = exp_count();
    acc = (bus.wr_pvld && exp_rdy() != 0) ? 1 : 0;
    pd  = int'(bus.wr_pd);
    @(posedge clk);
    if (!rstn) begin
      m_pushes = 0; m_we = 0; m_wa = 0; m_wd = 0; m_gray = 0; m_ovf = 0;
    end else begin
      m_gray = gr(m_pushes & 7);
      m_we   = acc;
      if (acc != 0) begin
        m_wa = m_pushes & 3;
        m_wd = pd;
        m_pushes++;
      end
      if (cnt > 4) m_ovf = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.wr_pvld = 1'b0;
    bus.wr_pd = '0;
    bus.enable_w = 1'b1;
    bus.rd_ptr_gray_sync = '0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.wr_pvld = 1'b0;
    bus.wr_pd = 8'h5A;
    bus.enable_w = 1'b1;
    bus.rd_ptr_gray_sync = '0;
    for (int i = 0; i < 3; i++) tick();
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.ram_we !== 1'b0 || bus.ram_wa !== 2'd0 || bus.ram_wd !== 8'd0) begin
      failures++;
      $display("FAIL reset_ram: we=%0b wa=%0d wd=%0h expected 0/0/0", bus.ram_we, bus.ram_wa, bus.ram_wd);
    end
    checks++;
    if (bus.wr_ptr_gray !== 3'd0 || bus.wr_count !== 3'd0 || bus.ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ptr: gray=%0d count=%0d ovf=%0b expected 0/0/0", bus.wr_ptr_gray, bus.wr_count, bus.ovf_err);
    end
    checks++;
    if (bus.wr_prdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_prdy: got %0b expected 1", bus.wr_prdy);
    end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = 8'hA0 + 8'(i);
      bus.wr_pvld = 1'b1;
      bus.wr_pd = d;
      tick();
      checks++;
      if (bus.ram_we !== 1'b1 || bus.ram_wa !== 2'(i) || bus.ram_wd !== d) begin
        failures++;
        $display("FAIL fill_write%0d: we=%0b wa=%0d wd=%0h expected 1/%0d/%0h", i, bus.ram_we, bus.ram_wa, bus.ram_wd, i, d);
      end
    end
    bus.wr_pd = 8'hA4;
    #1;
    checks++;
    if (bus.wr_count !== 3'd4 || bus.wr_prdy !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: count=%0d prdy=%0b expected 4/0", bus.wr_count, bus.wr_prdy);
    end
    tick();
    checks++;
    if (bus.ram_we !== 1'b0 || bus.ram_wa !== 2'd3 || bus.ram_wd !== 8'hA3 || bus.wr_count !== 3'd4) begin
      failures++;
      $display("FAIL fill_held: we=%0b wa=%0d wd=%0h count=%0d expected 0/3/a3/4", bus.ram_we, bus.ram_wa, bus.ram_wd, bus.wr_count);
    end
    bus.wr_pvld = 1'b0;
  endtask

  task automatic test_gray_wrap();
    int seq[9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    logic [2:0] prev;
    do_reset();
    prev = bus.wr_ptr_gray;
    for (int i = 0; i < 10; i++) begin
      bus.wr_pvld = (i < 9);
      bus.wr_pd = 8'(i);
      bus.rd_ptr_gray_sync = 3'(gr(i & 7));
      tick();
      if (i < 9) begin
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_wa !== 2'(i % 4)) begin
          failures++;
          $display("FAIL wrap_wa%0d: we=%0b wa=%0d expected 1/%0d", i, bus.ram_we, bus.ram_wa, i % 4);
        end
      end
      if (i >= 1) begin
        checks++;
        if (bus.wr_ptr_gray !== 3'(seq[i-1]) || $countones(bus.wr_ptr_gray ^ prev) != 1) begin
          failures++;
          $display("FAIL wrap_gray%0d: got %0d prev %0d expected %0d", i, bus.wr_ptr_gray, prev, seq[i-1]);
        end
        prev = bus.wr_ptr_gray;
      end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    bus.wr_pvld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_pd = 8'h10 + 8'(i);
      tick();
    end
    bus.wr_pvld = 1'b0;
    #1;
    checks++;
    if (bus.wr_count !== 3'd4 || bus.wr_prdy !== 1'b0) begin
      failures++;
      $display("FAIL pop_full: count=%0d prdy=%0b expected 4/0", bus.wr_count, bus.wr_prdy);
    end
    bus.rd_ptr_gray_sync = 3'd1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd = 8'h55;
    #1;
    checks++;
    if (bus.wr_count !== 3'd3 || bus.wr_prdy !== 1'b1) begin
      failures++;
      $display("FAIL pop_ready: count=%0d prdy=%0b expected 3/1", bus.wr_count, bus.wr_prdy);
    end
    tick();
    bus.wr_pvld = 1'b0;
    checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_wa !== 2'd0 || bus.ram_wd !== 8'h55) begin
      failures++;
      $display("FAIL pop_write: we=%0b wa=%0d wd=%0h expected 1/0/55", bus.ram_we, bus.ram_wa, bus.ram_wd);
    end
  endtask

  task automatic test_dft_gate();
    do_reset();
    bus.wr_pvld = 1'b1;
    bus.wr_pd = 8'hC3;
    tick();
    bus.enable_w = 1'b0;
    #1;
    checks++;
    if (bus.wr_prdy !== 1'b0 || bus.wr_clk_en !== 1'b0 || bus.ram_we !== 1'b1) begin
      failures++;
      $display("FAIL dft_gate: prdy=%0b clk_en=%0b we=%0b expected 0/0/1", bus.wr_prdy, bus.wr_clk_en, bus.ram_we);
    end
    tick();
    checks++;
    if (bus.ram_we !== 1'b0 || bus.wr_ptr_gray !== 3'd1 || bus.ram_wd !== 8'hC3) begin
      failures++;
      $display("FAIL dft_drain: we=%0b gray=%0d wd=%0h expected 0/1/c3", bus.ram_we, bus.wr_ptr_gray, bus.ram_wd);
    end
    tick();
    checks++;
    if (bus.ram_we !== 1'b0 || bus.wr_count !== 3'd1) begin
      failures++;
      $display("FAIL dft_hold: we=%0b count=%0d expected 0/1", bus.ram_we, bus.wr_count);
    end
    bus.wr_pvld = 1'b0;
    bus.enable_w = 1'b1;
  endtask

  task automatic test_inconsistent();
    do_reset();
    bus.wr_pvld = 1'b1;
    tick();
    bus.wr_pvld = 1'b1;
    bus.rd_ptr_gray_sync = 3'(gr(3));
    #1;
    checks++;
    if (bus.wr_count !== 3'd6 || bus.wr_prdy !== 1'b0) begin
      failures++;
      $display("FAIL bad_ptr_count: count=%0d prdy=%0b expected 6/0", bus.wr_count, bus.wr_prdy);
    end
    tick();
    bus.wr_pvld = 1'b0;
    bus.rd_ptr_gray_sync = '0;
    checks++;
    if (bus.ovf_err !== 1'b1 || bus.ram_we !== 1'b0) begin
      failures++;
      $display("FAIL bad_ptr_set: ovf=%0b we=%0b expected 1/0", bus.ovf_err, bus.ram_we);
    end
    tick();
    tick();
    checks++;
    if (bus.ovf_err !== 1'b1 || bus.wr_count !== 3'd1) begin
      failures++;
      $display("FAIL bad_ptr_sticky: ovf=%0b count=%0d expected 1/1", bus.ovf_err, bus.wr_count);
    end
    do_reset();
    checks++;
    if (bus.ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL bad_ptr_clear: ovf=%0b expected 0", bus.ovf_err);
    end
  endtask

  task automatic test_random();
    int rd_pops;
    do_reset();
    rd_pops = 0;
    for (int c = 0; c < 600; c++) begin
      rstn = ($urandom_range(0, 79) != 0);
      bus.enable_w = ($urandom_range(0, 7) != 0);
      bus.wr_pvld = 1'($urandom_range(0, 1));
      bus.wr_pd = 8'($urandom);
      if (!rstn) rd_pops = 0;
      else if (rd_pops < m_pushes && $urandom_range(0, 1) == 1) rd_pops++;
      bus.rd_ptr_gray_sync = 3'(gr(rd_pops & 7));
      #1;
      checks++;
      if (bus.wr_count !== 3'(exp_count()) || bus.wr_prdy !== 1'(exp_rdy()) || bus.wr_clk_en !== 1'(exp_clk_en())) begin
        failures++;
        $display("FAIL rand_comb c=%0d: count=%0d prdy=%0b clk_en=%0b expected %0d/%0d/%0d",
                 c, bus.wr_count, bus.wr_prdy, bus.wr_clk_en, exp_count(), exp_rdy(), exp_clk_en());
      end
      tick();
      checks++;
      if (bus.ram_we !== 1'(m_we) || bus.ram_wa !== 2'(m_wa) || bus.ram_wd !== 8'(m_wd) ||
          bus.wr_ptr_gray !== 3'(m_gray) || bus.ovf_err !== 1'(m_ovf)) begin
        failures++;
        $display("FAIL rand_reg c=%0d: we=%0b wa=%0d wd=%0h gray=%0d ovf=%0b expected %0d/%0d/%0h/%0d/%0d",
                 c, bus.ram_we, bus.ram_wa, bus.ram_wd, bus.wr_ptr_gray, bus.ovf_err, m_we, m_wa, m_wd, m_gray, m_ovf);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_pushes = 0; m_we = 0; m_wa = 0; m_wd = 0; m_gray = 0; m_ovf = 0;
    rstn = 1'b0;
    bus.wr_pvld = 1'b0;
    bus.wr_pd = '0;
    bus.enable_w = 1'b1;
    bus.rd_ptr_gray_sync = '0;
    #1;
    test_reset();
    test_fill();
    test_gray_wrap();
    test_full_pop();
    test_dft_gate();
    test_inconsistent();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nvdla_afifo_wr_ctrl.md
# nvdla_afifo_wr_ctrl

Write-domain controller for NVDLA asynchronous FIFOs. It sits directly downstream of the one-hot DFT write-clock enable source and consumes its `enable_w`. It accepts valid/ready pushes and drives the FIFO RAM write port. It maintains binary and Gray write pointers, detects full against the already-synchronized read pointer, and produces the functional write-clock-gate enable ANDed with the DFT enable.

## Interface
- `DEPTH_LOG2`, default 5: log2 of FIFO depth. Depth = 2^DEPTH_LOG2. Legal range 1..10.
- `WIDTH`, default 32: payload width in bits.
- `AW` (local) = `DEPTH_LOG2`. Pointers are AW+1 bits wide.

Ports:
- `nvdla_core_clk`  in  1  write-domain clock; the only clock.
- `nvdla_core_rstn`  in  1  reset, synchronous and active-low.
- `wr_pvld`  in  1  push valid.
- `wr_prdy`  out  1  push ready.
- `wr_pd`  in  WIDTH  push payload.
- `rd_ptr_gray_sync`  in  AW+1  read pointer, Gray-coded, already synchronized into this domain.
- `enable_w`  in  1  DFT one-hot write enable. 1 in functional mode.
- `ram_we`  out  1  RAM write enable.
- `ram_wa`  out  AW  RAM write address.
- `ram_wd`  out  WIDTH  RAM write data.
- `wr_ptr_gray`  out  AW+1  registered Gray write pointer, for crossing to the read domain.
- `wr_count`  out  AW+1  occupancy as seen by the write side.
- `wr_clk_en`  out  1  write-clock-gate enable.
- `ovf_err`  out  1  sticky pointer-inconsistency flag.

## Operation
- **Accept:** `acc = wr_pvld & wr_prdy`.
- **Ready:** `wr_prdy = enable_w & (wr_count < 2^AW)`. This is combinational from registered state plus `enable_w`.
- **Read pointer:** `rd_ptr_bin` = Gray-to-binary conversion of `rd_ptr_gray_sync`, combinational.
- **Occupancy:** `wr_count = wr_ptr_bin - rd_ptr_bin`, modulo 2^(AW+1), combinational.
  - Full when `wr_count == 2^AW`.
- **Write pointer:** `wr_ptr_bin` (internal, AW+1 bits) increments by 1 on every `acc`. It wraps from 2^(AW+1)-1 to 0.
- **RAM write stage (registered):**
  - `ram_we <= acc`.
  - When `acc`: `ram_wa <= wr_ptr_bin[AW-1:0]` (pre-increment value) and `ram_wd <= wr_pd`.
  - When not `acc`: `ram_wa` and `ram_wd` hold their values.
- **Gray publish:** `wr_ptr_gray <= bin2gray(wr_ptr_bin)` every cycle.
  - The Gray pointer therefore lags the binary pointer by one cycle.
  - The read side can never see a pointer covering an entry before its RAM write cycle has completed.
- **Illegal occupancy:** `wr_count > 2^AW` means the read pointer is ahead of or inconsistent with the write pointer.
  - `wr_prdy` is 0, because the value is not less than 2^AW.
  - `ovf_err` is set and stays set until reset.
- **Clock-gate enable:** `wr_clk_en = enable_w & (wr_pvld | ram_we | gray_pend)`.
  - `gray_pend = (wr_ptr_gray != bin2gray(wr_ptr_bin))`.
- **Test mode (`enable_w = 0`):**
  - `wr_prdy` and `wr_clk_en` are 0.
  - No new accepts occur.
  - An in-flight `ram_we` or Gray update still completes on the next edge.

## Timing
- **Reset** (`nvdla_core_rstn` = 0 sampled at an edge):
  - `wr_ptr_bin`, `wr_ptr_gray`, `ram_we`, `ram_wa`, `ram_wd` and `ovf_err` all become 0.
  - `wr_count` then equals `0 - rd_ptr_bin`; this is 0 when the read side is also in reset.
- **Reset mid-operation:** any pending RAM write or Gray update is dropped.
- **Latency:** accept at cycle t → `ram_we`=1 at t+1 → `wr_ptr_gray` updated at t+2.
- **Throughput:** 1 push per cycle while not full.
- **Full boundary:** the accept that makes `wr_count` equal to 2^AW drops `wr_prdy` in the very next cycle. There is no skid.
- **Simultaneous pop:** if `rd_ptr_gray_sync` advances in the same cycle that the count reaches full, `wr_prdy` reflects both values combinationally in the following cycle.
- **Back-to-back accepts:** `ram_wa` increments by 1 each cycle and wraps from 2^AW-1 to 0.
- **Gray output:** changes by exactly one bit per increment.

## Test plan
- **Reset:** `DEPTH_LOG2`=2, `rd_ptr_gray_sync`=0, hold reset 3 cycles → all outputs 0 and `wr_prdy`=1 after release.
- **Fill to full:** 4 back-to-back pushes of data 0xA0..0xA3 → `ram_we`=1 on cycles 1..4 with `ram_wa` 0,1,2,3 and matching data. `wr_count`=4, `wr_prdy`=0 on cycle 4. A 5th push is held and not written.
- **Gray wrap:** with the read side tracking, 8 pushes then a 9th → `wr_ptr_gray` sequence 1,3,2,6,7,5,4,0,1, each value one cycle after the matching `ram_we`. `ram_wa` wraps 3→0.
- **Full then pop:** from full, `rd_ptr_gray_sync` steps 0→1 → `wr_count`=3 and `wr_prdy`=1 that cycle. A push is accepted and written to `ram_wa`=0.
- **DFT gate:** drop `enable_w` while `wr_pvld`=1 → `wr_prdy`=0 and `wr_clk_en`=0. The pending `ram_we` from the prior accept still fires once.
- **Inconsistent pointer:** at `wr_ptr_bin`=1, force `rd_ptr_gray_sync`=gray(3) → `wr_count`=6, `wr_prdy`=0. `ovf_err` is set and stays 1 after the pointer is restored, until reset.
